// File: rtl/spi_adc_scanner_if.sv
// rtl/spi_adc_scanner_if.sv - control, result and ADC pin bundle of the SPI ADC scanner
interface spi_adc_scanner_if #(
  parameter int N_CH       = 1,
  parameter int CH_W       = 1,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  continuous;
  logic                  ready;
  logic                  busy;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data;
  logic [CH_W-1:0]       data_ch;
  logic [N_CH-1:0]       adc_cs_n;
  logic                  adc_sck;
  logic                  adc_sdo;

  // Scanner side: drives results and the SPI pins.
  modport master (
    input  start, continuous, adc_sdo,
    output ready, busy, data_valid, data, data_ch, adc_cs_n, adc_sck
  );

  // Application / board side.
  modport slave (
    output start, continuous, adc_sdo,
    input  ready, busy, data_valid, data, data_ch, adc_cs_n, adc_sck
  );
endinterface

// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - read-only CPOL=1 SPI master scanning N serial ADCs
module spi_adc_scanner #(
  parameter int CLK_DIV    = 25,
  parameter int FRAME_BITS = 16,
  parameter int DATA_LSB   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int N_CH       = 1,
  parameter int CH_W       = 1,
  parameter int CS_GAP     = 4,
  parameter int PERIOD     = 50000
) (
  input  logic              clk,
  input  logic              reset,
  spi_adc_scanner_if.master bus
);
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int DIV_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int PER_W   = $clog2(PERIOD + 1);
  // Only the bits up to the top of the data field are kept; earlier bits fall off the top.
  localparam int SR_W    = DATA_LSB + DATA_WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(FRAME_BITS);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
  localparam logic [PER_W-1:0] PER_SAT  = PER_W'(PERIOD);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  CS_IDLE  = '1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_WAIT} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [PER_W-1:0]      per_cnt;
  logic [CH_W-1:0]       ch;
  logic [SR_W-1:0]       shreg;
  logic [N_CH-1:0]       cs_n;
  logic                  sck;
  logic                  ready_q;
  logic                  dvalid;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CH_W-1:0]       data_ch_q;

  function automatic logic [N_CH-1:0] cs_sel(input logic [CH_W-1:0] c);
    cs_sel = ~(N_CH'(1) << c);
  endfunction

  // Scan sequencer: chip select, SCK generation, shifting, result strobe and scan period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      per_cnt   <= '0;
      ch        <= '0;
      shreg     <= '0;
      cs_n      <= CS_IDLE;
      sck       <= 1'b1;
      ready_q   <= 1'b1;
      dvalid    <= 1'b0;
      data_q    <= '0;
      data_ch_q <= '0;
    end else begin
      dvalid <= 1'b0;
      // Saturate so a long WAIT never wraps and restarts late.
      if (per_cnt != PER_SAT) per_cnt <= per_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.start || bus.continuous) begin
            ch      <= '0;
            per_cnt <= '0;
            div_cnt <= '0;
            cs_n    <= cs_sel('0);
            ready_q <= 1'b0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            state   <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == BITS_ALL) begin
              // SCK has been high for a full half-period after the last rise.
              cs_n      <= CS_IDLE;
              data_q    <= shreg[DATA_LSB +: DATA_WIDTH];
              data_ch_q <= ch;
              dvalid    <= 1'b1;
              bit_cnt   <= '0;
              state     <= S_GAP;
            end else if (!sck) begin
              sck     <= 1'b1;
              shreg   <= (shreg << 1) | SR_W'(bus.adc_sdo);
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sck <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            if (ch != CH_LAST) begin
              ch    <= ch + 1'b1;
              cs_n  <= cs_sel(ch + 1'b1);
              state <= S_SETUP;
            end else if (bus.continuous) begin
              state <= S_WAIT;
            end else begin
              ready_q <= 1'b1;
              state   <= S_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.continuous) begin
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else if (per_cnt >= PER_LAST) begin
            ch      <= '0;
            per_cnt <= '0;
            cs_n    <= cs_sel('0);
            state   <= S_SETUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = ~ready_q;
  assign bus.data_valid = dvalid;
  assign bus.data       = data_q;
  assign bus.data_ch    = data_ch_q;
  assign bus.adc_cs_n   = cs_n;
  assign bus.adc_sck    = sck;
endmodule
